uart_cmd_host: RTL

//  Upstream command source for the system's RX_IN pin: accepts one host command per handshake
//  and serializes it as a UART byte frame sequence in the system's command protocol
//  (0xAA reg write, 0xBB reg read, 0xCC ALU with operands, 0xDD ALU without operands).

---
 rtl/uart_cmd_host_pkg.sv | 42 ++++
 rtl/uart_cmd_host_if.sv | 43 ++++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_cmd_host.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_host_pkg.sv
// rtl/uart_cmd_host_pkg.sv - opcodes, command encodings, FSM states and frame-length lookup
// Break states exist only when UART_CMD_HOST_BREAK_EN is defined.
package uart_cmd_host_pkg;

  localparam logic [7:0] OP_WRITE   = 8'hAA;
  localparam logic [7:0] OP_READ    = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  localparam int BREAK_LOW_BITS = 12;

  typedef enum logic [1:0] {
    CMD_WRITE   = 2'd0,
    CMD_READ    = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
`ifdef UART_CMD_HOST_BREAK_EN
    ,
    ST_BRK_LO,
    ST_BRK_HI
`endif
  } state_e;

  function automatic logic [2:0] frame_len(input cmd_type_e t);
    case (t)
      CMD_WRITE:   frame_len = 3'd3;
      CMD_READ:    frame_len = 3'd2;
      CMD_ALU_OP:  frame_len = 3'd4;
      default:     frame_len = 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_host_if.sv
// rtl/uart_cmd_host_if.sv - command handshake and serial line bundle for uart_cmd_host
// break_req is present only when UART_CMD_HOST_BREAK_EN is defined.
interface uart_cmd_host_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 4,
  parameter int FUNC_WIDTH = 4,
  parameter int DIV_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_type;
  logic [ADDR_SIZE-1:0]  cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data0;
  logic [DATA_WIDTH-1:0] cmd_data1;
  logic [FUNC_WIDTH-1:0] cmd_func;
  logic                  par_en;
  logic                  par_typ;
  logic [DIV_WIDTH-1:0]  baud_div;
  logic                  tx_line;
  logic                  busy;
  logic                  cmd_done;
`ifdef UART_CMD_HOST_BREAK_EN
  logic                  break_req;
`endif

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_data0, cmd_data1, cmd_func,
           par_en, par_typ, baud_div,
`ifdef UART_CMD_HOST_BREAK_EN
    output break_req,
`endif
    input  cmd_ready, tx_line, busy, cmd_done
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_data0, cmd_data1, cmd_func,
           par_en, par_typ, baud_div,
`ifdef UART_CMD_HOST_BREAK_EN
    input  break_req,
`endif
    output cmd_ready, tx_line, busy, cmd_done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable down-counter; tick marks the last cycle of a bit period
module uart_bit_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == '0);
endmodule

// File: rtl/uart_cmd_host.sv
// rtl/uart_cmd_host.sv - serializes one host command per handshake as UART byte frames
// Optional line-break generator enabled by defining UART_CMD_HOST_BREAK_EN.
module uart_cmd_host
  import uart_cmd_host_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 4,
  parameter int FUNC_WIDTH = 4,
  parameter int DIV_WIDTH  = 16,
  parameter int GAP_BITS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_cmd_host_if.slave    bus
);
  state_e                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  cmd_type_e             type_q, type_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic [FUNC_WIDTH-1:0] func_q, func_d;
  logic                  pe_q, pe_d;
  logic                  pt_q, pt_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic                  done_q, done_d;

  logic                  load, tick, last_byte, tx;
  logic [DIV_WIDTH-1:0]  load_val;
  logic [DATA_WIDTH-1:0] cur_byte;

  uart_bit_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .tick     (tick)
  );

  always_comb begin
    cur_byte = DATA_WIDTH'(OP_ALU_NOP);
    case (type_q)
      CMD_WRITE:
        case (byte_idx_q)
          2'd0:    cur_byte = DATA_WIDTH'(OP_WRITE);
          2'd1:    cur_byte = DATA_WIDTH'(addr_q);
          default: cur_byte = data0_q;
        endcase
      CMD_READ:
        cur_byte = (byte_idx_q == 2'd0) ? DATA_WIDTH'(OP_READ) : DATA_WIDTH'(addr_q);
      CMD_ALU_OP:
        case (byte_idx_q)
          2'd0:    cur_byte = DATA_WIDTH'(OP_ALU_OP);
          2'd1:    cur_byte = data0_q;
          2'd2:    cur_byte = data1_q;
          default: cur_byte = DATA_WIDTH'(func_q);
        endcase
      default:
        cur_byte = (byte_idx_q == 2'd0) ? DATA_WIDTH'(OP_ALU_NOP) : DATA_WIDTH'(func_q);
    endcase
  end

  assign last_byte = ({1'b0, byte_idx_q} == (frame_len(type_q) - 3'd1));

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    type_d     = type_q;
    addr_d     = addr_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    func_d     = func_q;
    pe_d       = pe_q;
    pt_d       = pt_q;
    baud_d     = baud_q;
    done_d     = 1'b0;
    load       = 1'b0;
    load_val   = baud_q;

    if (state_q == ST_IDLE) begin
`ifdef UART_CMD_HOST_BREAK_EN
      if (bus.break_req) begin
        state_d   = ST_BRK_LO;
        bit_idx_d = '0;
        baud_d    = bus.baud_div;
        load      = 1'b1;
        load_val  = bus.baud_div;
      end else
`endif
      if (bus.cmd_valid) begin
        state_d    = ST_START;
        byte_idx_d = '0;
        type_d     = cmd_type_e'(bus.cmd_type);
        addr_d     = bus.cmd_addr;
        data0_d    = bus.cmd_data0;
        data1_d    = bus.cmd_data1;
        func_d     = bus.cmd_func;
        pe_d       = bus.par_en;
        pt_d       = bus.par_typ;
        baud_d     = bus.baud_div;
        load       = 1'b1;
        load_val   = bus.baud_div;
      end
    end else if (tick) begin
      // every bit period, including the next byte's start bit, reloads from the latched divider
      load = 1'b1;
      case (state_q)
        ST_START: begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
        ST_DATA: begin
          if (bit_idx_q == 4'(DATA_WIDTH - 1))
            state_d = pe_q ? ST_PARITY : ST_STOP;
          else
            bit_idx_d = bit_idx_q + 4'd1;
        end
        ST_PARITY: state_d = ST_STOP;
        ST_STOP, ST_GAP: begin
          if (state_q == ST_STOP && GAP_BITS > 0) begin
            state_d   = ST_GAP;
            bit_idx_d = '0;
          end else if (state_q == ST_GAP && bit_idx_q != 4'(GAP_BITS - 1)) begin
            bit_idx_d = bit_idx_q + 4'd1;
          end else if (last_byte) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_START;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
`ifdef UART_CMD_HOST_BREAK_EN
        ST_BRK_LO: begin
          if (bit_idx_q == 4'(BREAK_LOW_BITS - 1))
            state_d = ST_BRK_HI;
          else
            bit_idx_d = bit_idx_q + 4'd1;
        end
        ST_BRK_HI: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      type_q     <= CMD_WRITE;
      addr_q     <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      func_q     <= '0;
      pe_q       <= 1'b0;
      pt_q       <= 1'b0;
      baud_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      func_q     <= func_d;
      pe_q       <= pe_d;
      pt_q       <= pt_d;
      baud_q     <= baud_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = cur_byte[bit_idx_q[$clog2(DATA_WIDTH)-1:0]];
      ST_PARITY: tx = (^cur_byte) ^ pt_q;
`ifdef UART_CMD_HOST_BREAK_EN
      ST_BRK_LO: tx = 1'b0;
`endif
      default:   tx = 1'b1;
    endcase
  end

  assign bus.tx_line   = tx;
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.cmd_done  = done_q;
endmodule
